pc_redirect_ctrl: RTL and testbench

- Parametrised PC-redirect controller in the MEM stage of the pipeline.
- Detects any instruction in MEM that writes the PC register: ALU-class (ADD/NAND family, all cond variants), LW, and LM at the beat that targets the PC.
- Holds the target until fetch accepts it, then sequences a multi-cycle flush of younger stages.
- Defers an LM-sourced redirect until the final LM beat.

---
 rtl/pc_redirect_pkg.sv | 21 ++
 rtl/redirect_detect.sv | 40 ++++
 rtl/pc_redirect_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: shared constants and types for the PC-redirect controller.
//   OPC_ADD / OPC_NAND : ALU-class opcodes that may target the PC
//   COND_*             : condition-field encodings
//   state_t            : controller FSM states
package pc_redirect_pkg;

  localparam logic [3:0] OPC_ADD  = 4'b0000;
  localparam logic [3:0] OPC_NAND = 4'b0010;

  localparam logic [1:0] COND_PLAIN = 2'b00;
  localparam logic [1:0] COND_Z     = 2'b01;
  localparam logic [1:0] COND_C     = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND_LM = 2'd1,
    ISSUE   = 2'd2,
    FLUSH   = 2'd3
  } state_t;

endpackage

// File: rtl/redirect_detect.sv
// redirect_detect: combinational classifier for MEM-stage writes to the PC.
//   inputs : MEM-stage valid/opcode/rd/reg_write/is_lw/is_lm, alu_result, mem_rdata
//   outputs: alu_hit, ld_hit, lm_hit (mutually exclusive, alu > ld > lm),
//            tgt_data (redirect target selected for the winning hit)
module redirect_detect
  import pc_redirect_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int PC_REG = 7,
  parameter int OPC_W  = 4
) (
  input  logic              mem_valid,
  input  logic [OPC_W-1:0]  mem_opcode,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_is_lw,
  input  logic              mem_is_lm,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              alu_hit,
  output logic              ld_hit,
  output logic              lm_hit,
  output logic [DATA_W-1:0] tgt_data
);

  logic hit;
  logic is_alu;

  // mem_reg_write is already condition-qualified, so cond variants need no check here
  assign hit     = mem_valid & mem_reg_write & (mem_rd == REG_AW'(PC_REG));
  assign is_alu  = (mem_opcode == OPC_W'(OPC_ADD)) | (mem_opcode == OPC_W'(OPC_NAND));

  assign alu_hit = hit & is_alu;
  assign ld_hit  = hit & mem_is_lw & ~is_alu;
  assign lm_hit  = hit & mem_is_lm & ~is_alu & ~mem_is_lw;

  assign tgt_data = alu_hit ? alu_result : mem_rdata;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: MEM-stage PC-redirect controller.
//   Detects writes to the PC register (ALU, LW, LM beat), holds the target
//   on new_pc/pc_load until fetch_ready, then flushes younger stages for
//   FLUSH_CYC cycles. LM-sourced redirects wait for the final LM beat.
//   Optional macro REDIRECT_STATS_EN: saturating accepted-redirect counter
//   on redirect_count; otherwise redirect_count is tied to 0.
// Ports: clk, reset (sync, active-high), mem_* MEM-stage info, alu_result,
//   mem_rdata, seq_pc, fetch_ready -> new_pc, pc_load, flush, busy,
//   redirect_count.
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 3,
  parameter int PC_REG    = 7,
  parameter int OPC_W     = 4,
  parameter int FLUSH_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [OPC_W-1:0]  mem_opcode,
  input  logic [1:0]        mem_cond,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_is_lw,
  input  logic              mem_is_lm,
  input  logic              mem_lm_last,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] seq_pc,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] new_pc,
  output logic              pc_load,
  output logic              flush,
  output logic              busy,
  output logic [15:0]       redirect_count
);

  localparam int CNT_W = $clog2(FLUSH_CYC + 1);

  state_t            state;
  logic [DATA_W-1:0] tgt;
  logic [CNT_W-1:0]  cnt;
  logic              alu_hit, ld_hit, lm_hit;
  logic [DATA_W-1:0] tgt_data;

  // condition gating is already folded into mem_reg_write
  logic cond_unused;
  assign cond_unused = ^mem_cond;

  redirect_detect #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_REG(PC_REG), .OPC_W(OPC_W)
  ) u_detect (
    .mem_valid    (mem_valid),
    .mem_opcode   (mem_opcode),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .mem_is_lw    (mem_is_lw),
    .mem_is_lm    (mem_is_lm),
    .alu_result   (alu_result),
    .mem_rdata    (mem_rdata),
    .alu_hit      (alu_hit),
    .ld_hit       (ld_hit),
    .lm_hit       (lm_hit),
    .tgt_data     (tgt_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tgt     <= '0;
      cnt     <= '0;
      pc_load <= 1'b0;
      flush   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (alu_hit | ld_hit | (lm_hit & mem_lm_last)) begin
            tgt     <= tgt_data;
            state   <= ISSUE;
            pc_load <= 1'b1;
            flush   <= 1'b1;
          end else if (lm_hit) begin
            tgt   <= tgt_data;
            state <= PEND_LM;
          end
        end
        PEND_LM: begin
          // only a later beat that again targets the PC may replace the target
          if (lm_hit) tgt <= tgt_data;
          if (mem_valid & mem_is_lm & mem_lm_last) begin
            state   <= ISSUE;
            pc_load <= 1'b1;
            flush   <= 1'b1;
          end
        end
        ISSUE: begin
          if (fetch_ready) begin
            cnt     <= CNT_W'(FLUSH_CYC);
            state   <= FLUSH;
            pc_load <= 1'b0;
          end
        end
        FLUSH: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign new_pc = pc_load ? tgt : seq_pc;

`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      redirect_count <= '0;
    else if ((state == ISSUE) && fetch_ready && (redirect_count != 16'hFFFF))
      redirect_count <= redirect_count + 16'd1;
  end
`else
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  localparam int FLUSH_CYC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic [3:0]  mem_opcode;
  logic [1:0]  mem_cond;
  logic [2:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_is_lw;
  logic        mem_is_lm;
  logic        mem_lm_last;
  logic [15:0] alu_result;
  logic [15:0] mem_rdata;
  logic [15:0] seq_pc;
  logic        fetch_ready;
  logic [15:0] new_pc;
  logic        pc_load;
  logic        flush;
  logic        busy;
  logic [15:0] redirect_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pc_redirect_ctrl #(
    .DATA_W(16), .REG_AW(3), .PC_REG(7), .OPC_W(4), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_opcode(mem_opcode),
    .mem_cond(mem_cond), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_is_lw(mem_is_lw), .mem_is_lm(mem_is_lm), .mem_lm_last(mem_lm_last),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .seq_pc(seq_pc),
    .fetch_ready(fetch_ready), .new_pc(new_pc), .pc_load(pc_load),
    .flush(flush), .busy(busy), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a redirect is either waiting for the last LM beat,
  // outstanding toward fetch, or followed by a number of flush cycles left.
  bit        m_out, m_wait_lm;
  int        m_left;
  int        m_acc;
  logic [15:0] m_tgt;

  always @(posedge clk) begin
    bit pc_write;
    pc_write = mem_valid && mem_reg_write && (mem_rd == 3'd7);
    if (reset) begin
      m_out = 0; m_wait_lm = 0; m_left = 0; m_acc = 0; m_tgt = '0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (m_out) begin
      if (fetch_ready) begin
        m_out  = 0;
        m_left = FLUSH_CYC;
        if (m_acc < 65535) m_acc++;
      end
    end else if (m_wait_lm) begin
      if (pc_write && mem_is_lm && !mem_is_lw && mem_opcode != 4'd0 && mem_opcode != 4'd2)
        m_tgt = mem_rdata;
      if (mem_valid && mem_is_lm && mem_lm_last) begin
        m_wait_lm = 0;
        m_out = 1;
      end
    end else if (pc_write) begin
      if (mem_opcode == 4'd0 || mem_opcode == 4'd2) begin
        m_tgt = alu_result; m_out = 1;
      end else if (mem_is_lw) begin
        m_tgt = mem_rdata; m_out = 1;
      end else if (mem_is_lm) begin
        m_tgt = mem_rdata;
        if (mem_lm_last) m_out = 1; else m_wait_lm = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_pc_load", 32'(pc_load), 32'(m_out));
      chk("sb_flush", 32'(flush), 32'(m_out || m_left > 0));
      chk("sb_busy", 32'(busy), 32'(m_out || m_wait_lm || m_left > 0));
      chk("sb_new_pc", 32'(new_pc), 32'(m_out ? m_tgt : seq_pc));
`ifdef REDIRECT_STATS_EN
      chk("sb_count", 32'(redirect_count), 32'(m_acc));
`else
      chk("sb_count", 32'(redirect_count), 32'd0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    seq_pc = seq_pc + 16'd2;
  endtask

  task automatic idle();
    mem_valid = 0; mem_opcode = 4'b0100; mem_cond = 2'b00; mem_rd = 3'd0;
    mem_reg_write = 0; mem_is_lw = 0; mem_is_lm = 0; mem_lm_last = 0;
    alu_result = 16'h0; mem_rdata = 16'h0; fetch_ready = 1;
  endtask

  task automatic lm_beat(input logic [2:0] rd, input logic [15:0] d, input logic last);
    mem_valid = 1; mem_opcode = 4'b0110; mem_is_lm = 1; mem_is_lw = 0;
    mem_reg_write = 1; mem_rd = rd; mem_rdata = d; mem_lm_last = last;
  endtask

  initial begin
    int n;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    seq_pc = 16'h0100;
    idle();
    reset = 1;
    cyc(); cyc();
    chk_en = 1;
    #4;
    chk("rst_pc_load", 32'(pc_load), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_new_pc", 32'(new_pc), 32'(seq_pc));
    reset = 0;
    cyc();

    // ADD to PC, fetch ready at once: flush spans 1+FLUSH_CYC cycles
    mem_valid = 1; mem_opcode = 4'b0000; mem_cond = 2'b00; mem_rd = 3'd7;
    mem_reg_write = 1; alu_result = 16'h0040;
    cyc();
    idle();
    #4;
    chk("add_pc_load", 32'(pc_load), 1);
    chk("add_new_pc", 32'(new_pc), 32'h0040);
    n = flush ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      cyc(); #4;
      if (flush) n++;
    end
    chk("add_flush_len", 32'(n), 32'(1 + FLUSH_CYC));
    chk("add_busy_done", 32'(busy), 0);

    // ADZ with condition false: no redirect
    cyc();
    mem_valid = 1; mem_opcode = 4'b0000; mem_cond = 2'b01; mem_rd = 3'd7;
    mem_reg_write = 0; alu_result = 16'h0dead;
    cyc();
    idle();
    #4;
    chk("adz_pc_load", 32'(pc_load), 0);
    chk("adz_busy", 32'(busy), 0);
    chk("adz_new_pc", 32'(new_pc), 32'(seq_pc));

    // LM: rd=3, rd=7 (0x1234), rd=5 last
    cyc();
    lm_beat(3'd3, 16'h1111, 0);
    cyc();
    lm_beat(3'd7, 16'h1234, 0);
    cyc();
    lm_beat(3'd5, 16'h5555, 0);
    #4;
    chk("lm_pend_busy", 32'(busy), 1);
    chk("lm_pend_pc_load", 32'(pc_load), 0);
    mem_lm_last = 1;
    cyc();
    idle();
    #4;
    chk("lm_pc_load", 32'(pc_load), 1);
    chk("lm_new_pc", 32'(new_pc), 32'h1234);
    for (int i = 0; i < 6; i++) cyc();

    // LW to PC with fetch stalled 3 cycles
    mem_valid = 1; mem_opcode = 4'b0100; mem_is_lw = 1; mem_rd = 3'd7;
    mem_reg_write = 1; mem_rdata = 16'hBEEF;
    cyc();
    idle();
    fetch_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) fetch_ready = 1;
      #4;
      chk("lw_hold_pc_load", 32'(pc_load), 1);
      chk("lw_hold_new_pc", 32'(new_pc), 32'hBEEF);
      cyc();
    end
    #4;
    chk("lw_flush_pc_load", 32'(pc_load), 0);
    chk("lw_flush", 32'(flush), 1);
    for (int i = 0; i < 5; i++) cyc();
    #4;
`ifdef REDIRECT_STATS_EN
    chk("stats_count", 32'(redirect_count), 3);
`else
    chk("stats_count", 32'(redirect_count), 0);
`endif

    // reset during FLUSH
    cyc();
    mem_valid = 1; mem_opcode = 4'b0010; mem_rd = 3'd7; mem_reg_write = 1;
    alu_result = 16'h0080;
    cyc();
    idle();
    cyc();
    #4;
    chk("rf_in_flush", 32'(flush), 1);
    reset = 1;
    cyc();
    reset = 0;
    #4;
    chk("rf_flush", 32'(flush), 0);
    chk("rf_busy", 32'(busy), 0);
    chk("rf_pc_load", 32'(pc_load), 0);
    chk("rf_count", 32'(redirect_count), 0);

    // reset during PEND_LM
    cyc();
    lm_beat(3'd7, 16'h7777, 0);
    cyc();
    idle();
    #4;
    chk("rp_pend_busy", 32'(busy), 1);
    reset = 1;
    cyc();
    reset = 0;
    #4;
    chk("rp_busy", 32'(busy), 0);
    chk("rp_pc_load", 32'(pc_load), 0);
    lm_beat(3'd2, 16'h2222, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      idle();
      #4;
      chk("rp_no_redirect", 32'(pc_load), 0);
    end

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
